// File: rtl/mat_mul_host_seq_if.sv
// Bundle of the element stream ports and the control-unit matrix bus used
// by the host-side matrix-multiply sequencer.
// The master modport is the sequencer's view.
// The slave modport is the view of whoever drives the stream and plays the
// control unit.
interface mat_mul_host_seq_if #(
  parameter int W = 16,
  parameter int N = 3
);
  // element input stream
  logic             i_mode;
  logic             i_in_valid;
  logic             o_in_ready;
  logic [W-1:0]     i_in_data;
  // result output stream
  logic             o_out_valid;
  logic             i_out_ready;
  logic [W-1:0]     o_out_data;
  logic             o_out_last;
  // control-unit bus
  logic             o_en;
  logic             o_mode;
  logic [W*N*N-1:0] o_A;
  logic [W*N*N-1:0] o_B;
  logic [W*N*N-1:0] i_C;
  logic             i_done;

  modport master (
    input  i_mode, i_in_valid, i_in_data, i_out_ready, i_C, i_done,
    output o_in_ready, o_out_valid, o_out_data, o_out_last,
           o_en, o_mode, o_A, o_B
  );

  modport slave (
    output i_mode, i_in_valid, i_in_data, i_out_ready, i_C, i_done,
    input  o_in_ready, o_out_valid, o_out_data, o_out_last,
           o_en, o_mode, o_A, o_B
  );
endinterface

// File: rtl/mat_mul_host_seq.sv
// Host-side initiator for the systolic control unit.
// Streams in A then B (row-major) and packs them onto flat buses.
// Enables the control unit and counts enabled cycles until i_done.
// Captures C and streams it back out element by element.
// Element k = r*N+c sits at bits [W*(N*N-1-k) +: W], so the first element
// streamed lands at the MSB end of each flat bus.
module mat_mul_host_seq #(
  parameter int W  = 16,
  parameter int N  = 3,
  parameter int CW = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  mat_mul_host_seq_if.master    bus,
  output logic                  o_busy,
  output logic [CW-1:0]         o_run_cycles
);

  localparam int NE = N * N;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;
  localparam int BW = W * NE;

  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NE - 1);
  localparam logic [CW-1:0] RUN_ONE  = CW'(1);
  localparam logic [CW-1:0] RUN_MAX  = {CW{1'b1}};
  localparam logic [W-1:0]  DATA_ZERO = {W{1'b0}};
  localparam logic [BW-1:0] BUS_ZERO  = {BW{1'b0}};

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    RUN    = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  // Read slot k of a flat matrix bus.
  function automatic logic [W-1:0] get_slot(input logic [BW-1:0] vec,
                                            input logic [IW-1:0] k);
    return vec[W*(NE-1-int'(k)) +: W];
  endfunction

  // Return the flat matrix bus with slot k replaced by val.
  function automatic logic [BW-1:0] set_slot(input logic [BW-1:0] vec,
                                             input logic [IW-1:0] k,
                                             input logic [W-1:0]  val);
    logic [BW-1:0] res;
    res = vec;
    res[W*(NE-1-int'(k)) +: W] = val;
    return res;
  endfunction

  state_t           state_r;
  logic [IW-1:0]    idx_r;
  logic [BW-1:0]    a_r;
  logic [BW-1:0]    b_r;
  logic [BW-1:0]    c_r;
  logic             mode_r;
  logic             en_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             out_last_r;
  logic [W-1:0]     out_data_r;
  logic             busy_r;
  logic [CW-1:0]    run_cycles_r;

  logic             in_hs_s;
  logic             out_hs_s;
  logic             idx_last_s;
  logic [IW-1:0]    idx_inc_s;

  // Handshake decodes and index helpers shared by every state.
  always_comb begin
    in_hs_s    = bus.i_in_valid & in_ready_r;
    out_hs_s   = out_valid_r & bus.i_out_ready;
    idx_last_s = (idx_r == IDX_LAST);
    idx_inc_s  = idx_r + IDX_ONE;
  end

  // Sequencer: load A, load B, run the control unit, drain C; all outputs
  // are registered here so they change only on clock edges.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= LOAD_A;
      idx_r        <= IDX_ZERO;
      a_r          <= BUS_ZERO;
      b_r          <= BUS_ZERO;
      c_r          <= BUS_ZERO;
      mode_r       <= 1'b0;
      en_r         <= 1'b0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      out_data_r   <= DATA_ZERO;
      busy_r       <= 1'b0;
      run_cycles_r <= {CW{1'b0}};
    end else begin
      case (state_r)
        LOAD_A: begin
          if (in_hs_s) begin
            a_r <= set_slot(a_r, idx_r, bus.i_in_data);
            // mode belongs to the whole job, so take it with the first element
            if (idx_r == IDX_ZERO) begin
              mode_r <= bus.i_mode;
            end
            if (idx_last_s) begin
              idx_r   <= IDX_ZERO;
              state_r <= LOAD_B;
            end else begin
              idx_r <= idx_inc_s;
            end
          end
        end

        LOAD_B: begin
          if (in_hs_s) begin
            b_r <= set_slot(b_r, idx_r, bus.i_in_data);
            if (idx_last_s) begin
              idx_r        <= IDX_ZERO;
              state_r      <= RUN;
              en_r         <= 1'b1;
              in_ready_r   <= 1'b0;
              busy_r       <= 1'b1;
              run_cycles_r <= {CW{1'b0}};
            end else begin
              idx_r <= idx_inc_s;
            end
          end
        end

        RUN: begin
          // every RUN edge closes one cycle of o_en high, including the
          // edge that samples i_done
          if (run_cycles_r != RUN_MAX) begin
            run_cycles_r <= run_cycles_r + RUN_ONE;
          end
          if (bus.i_done) begin
            c_r         <= bus.i_C;
            en_r        <= 1'b0;
            state_r     <= DRAIN;
            idx_r       <= IDX_ZERO;
            out_valid_r <= 1'b1;
            // C register is loaded on this same edge, so slot 0 comes
            // straight from the incoming bus
            out_data_r  <= get_slot(bus.i_C, IDX_ZERO);
            out_last_r  <= (IDX_LAST == IDX_ZERO);
          end
        end

        DRAIN: begin
          if (out_hs_s) begin
            if (idx_last_s) begin
              idx_r       <= IDX_ZERO;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              state_r     <= LOAD_A;
              in_ready_r  <= 1'b1;
              busy_r      <= 1'b0;
            end else begin
              idx_r      <= idx_inc_s;
              out_data_r <= get_slot(c_r, idx_inc_s);
              out_last_r <= (idx_inc_s == IDX_LAST);
            end
          end
        end

        default: begin
          state_r     <= LOAD_A;
          idx_r       <= IDX_ZERO;
          en_r        <= 1'b0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_in_ready  = in_ready_r;
  assign bus.o_out_valid = out_valid_r;
  assign bus.o_out_data  = out_data_r;
  assign bus.o_out_last  = out_last_r;
  assign bus.o_en        = en_r;
  assign bus.o_mode      = mode_r;
  assign bus.o_A         = a_r;
  assign bus.o_B         = b_r;
  assign o_busy          = busy_r;
  assign o_run_cycles    = run_cycles_r;

endmodule

// File: tb/tb_mat_mul_host_seq.sv
// Self-checking bench for mat_mul_host_seq.
// Two instances (CW=16 and CW=4) receive identical inputs, so the narrow
// instance exposes run-counter saturation.
// The reference model packs matrices by shifting elements in order and
// predicts the counter as min(enabled cycles, 2^CW-1).
module tb_mat_mul_host_seq;
  localparam int W  = 16;
  localparam int N  = 3;
  localparam int NE = N * N;
  localparam int BW = W * NE;

  typedef logic [W-1:0] vec9_t [NE];

  logic clk;
  logic rst;
  logic          busy1, busy2;
  logic [15:0]   rc1;
  logic [3:0]    rc2;

  mat_mul_host_seq_if #(.W(W), .N(N)) bus1 ();
  mat_mul_host_seq_if #(.W(W), .N(N)) bus2 ();

  assign bus2.i_mode      = bus1.i_mode;
  assign bus2.i_in_valid  = bus1.i_in_valid;
  assign bus2.i_in_data   = bus1.i_in_data;
  assign bus2.i_out_ready = bus1.i_out_ready;
  assign bus2.i_C         = bus1.i_C;
  assign bus2.i_done      = bus1.i_done;

  mat_mul_host_seq #(.W(W), .N(N), .CW(16)) dut1 (
    .i_clk(clk), .i_rst(rst), .bus(bus1), .o_busy(busy1), .o_run_cycles(rc1)
  );
  mat_mul_host_seq #(.W(W), .N(N), .CW(4)) dut2 (
    .i_clk(clk), .i_rst(rst), .bus(bus2), .o_busy(busy2), .o_run_cycles(rc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BW-1:0] exp_a;
  logic [BW-1:0] exp_b;
  logic          exp_mode;

  // first element ends up at the MSB end after all shifts
  function automatic logic [BW-1:0] pack(input vec9_t e);
    logic [BW-1:0] acc;
    acc = '0;
    for (int k = 0; k < NE; k++) acc = (acc << W) | BW'(e[k]);
    return acc;
  endfunction

  task automatic rand_vec(output vec9_t v);
    for (int k = 0; k < NE; k++) v[k] = W'($urandom);
  endtask

  // Stream A then B; optionally random valid gaps and a spurious done in LOAD_B.
  task automatic do_load(input vec9_t a, input vec9_t b, input logic mode,
                         input bit rnd, input bit spurious);
    int i, guard;
    bit pulsed, hs;
    logic v;
    i = 0; guard = 0; pulsed = 0;
    exp_a = pack(a); exp_b = pack(b); exp_mode = mode;
    bus1.i_mode = mode;
    while (i < 2*NE && guard < 2000) begin
      guard++;
      if (bus1.i_done) begin
        bus1.i_done = 1'b0;
        n_checks++;
        if ({bus1.o_en, bus1.o_out_valid, busy1, bus1.o_in_ready} !== 4'b0001) begin
          n_fail++;
          $display("FAIL spurious_done: en/valid/busy/ready=%b required 0001",
                   {bus1.o_en, bus1.o_out_valid, busy1, bus1.o_in_ready});
        end
      end else if (spurious && !pulsed && i == NE + 3) begin
        bus1.i_done = 1'b1;
        pulsed = 1;
      end
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus1.i_in_valid = v;
      bus1.i_in_data  = (i < NE) ? a[i] : b[i-NE];
      hs = v && bus1.o_in_ready;
      @(negedge clk);
      if (hs) i++;
    end
    if (guard >= 2000) begin
      n_checks++; n_fail++;
      $display("FAIL load_timeout: accepted %0d required %0d", i, 2*NE);
    end
    // keep offering junk during the run; it must not be consumed
    bus1.i_in_valid = 1'b1;
    bus1.i_in_data  = 16'hdead;
  endtask

  // Hold i_done off for d cycles after o_en rises, then complete the run.
  task automatic do_run(input vec9_t c, input int d);
    int hi;
    int exp1, exp2;
    bus1.i_C = pack(c);
    n_checks++;
    if (bus1.o_en !== 1'b1) begin
      n_fail++; $display("FAIL en_rise: o_en=%b required 1", bus1.o_en);
    end
    hi = bus1.o_en ? 1 : 0;
    for (int j = 0; j < d; j++) begin
      @(negedge clk);
      if (bus1.o_en) hi++;
    end
    bus1.i_done = 1'b1;
    @(negedge clk);
    bus1.i_done = 1'b0;
    exp1 = (d + 1 > 65535) ? 65535 : d + 1;
    exp2 = (d + 1 > 15) ? 15 : d + 1;
    n_checks++;
    if (bus1.o_en !== 1'b0 || hi != d + 1) begin
      n_fail++; $display("FAIL en_window: o_en=%b high=%0d required 0 and %0d", bus1.o_en, hi, d + 1);
    end
    n_checks++;
    if (rc1 !== 16'(exp1)) begin
      n_fail++; $display("FAIL run_cycles: got %0d required %0d", rc1, exp1);
    end
    n_checks++;
    if (rc2 !== 4'(exp2)) begin
      n_fail++; $display("FAIL run_cycles_sat: got %0d required %0d", rc2, exp2);
    end
    n_checks++;
    if (bus1.o_A !== exp_a || bus1.o_B !== exp_b || bus1.o_mode !== exp_mode) begin
      n_fail++; $display("FAIL ab_hold: o_A=%h o_B=%h mode=%b required %h %h %b",
                         bus1.o_A, bus1.o_B, bus1.o_mode, exp_a, exp_b, exp_mode);
    end
    n_checks++;
    if (bus1.o_out_valid !== 1'b1 || busy1 !== 1'b1) begin
      n_fail++; $display("FAIL drain_entry: valid=%b busy=%b required 1 1", bus1.o_out_valid, busy1);
    end
    bus1.i_in_valid = 1'b0;
  endtask

  // Collect the nine C elements with optional random backpressure.
  task automatic do_drain(input vec9_t c, input bit rnd);
    int got, guard;
    bit stall;
    logic r;
    logic [W-1:0] prev;
    got = 0; guard = 0; stall = 0; prev = '0;
    while (got < NE && guard < 500) begin
      guard++;
      if (stall) begin
        n_checks++;
        if (bus1.o_out_data !== prev) begin
          n_fail++; $display("FAIL out_stable: got %h required %h", bus1.o_out_data, prev);
        end
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus1.i_out_ready = r;
      if (bus1.o_out_valid && r) begin
        n_checks++;
        if (bus1.o_out_data !== c[got]) begin
          n_fail++; $display("FAIL out_data[%0d]: got %h required %h", got, bus1.o_out_data, c[got]);
        end
        n_checks++;
        if (bus1.o_out_last !== (got == NE - 1)) begin
          n_fail++; $display("FAIL out_last[%0d]: got %b required %b", got, bus1.o_out_last, got == NE - 1);
        end
        got++;
      end
      stall = bus1.o_out_valid && !r;
      prev  = bus1.o_out_data;
      @(negedge clk);
    end
    bus1.i_out_ready = 1'b0;
    if (guard >= 500) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d elements required %0d", got, NE);
    end
    n_checks++;
    if ({bus1.o_out_valid, busy1, bus1.o_in_ready} !== 3'b001) begin
      n_fail++; $display("FAIL drain_exit: valid/busy/ready=%b required 001",
                         {bus1.o_out_valid, busy1, bus1.o_in_ready});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus1.o_A !== '0 || bus1.o_B !== '0 || bus1.o_out_data !== '0 || rc1 !== '0 ||
        rc2 !== '0 || bus1.o_mode !== 1'b0) begin
      n_fail++; $display("FAIL reset_data: A=%h B=%h out=%h rc=%0d mode=%b required all zero",
                         bus1.o_A, bus1.o_B, bus1.o_out_data, rc1, bus1.o_mode);
    end
    n_checks++;
    if ({bus1.o_en, bus1.o_out_valid, bus1.o_out_last, busy1} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: en/valid/last/busy=%b required 0000",
                         {bus1.o_en, bus1.o_out_valid, bus1.o_out_last, busy1});
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus1.o_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b required 1", bus1.o_in_ready);
    end
  endtask

  task automatic test_all_ones();
    vec9_t a, c;
    for (int k = 0; k < NE; k++) begin a[k] = 16'h3c00; c[k] = 16'h4200; end
    do_load(a, a, 1'b1, 0, 0);
    do_run(c, 6);
    do_drain(c, 0);
  endtask

  task automatic test_packing();
    vec9_t a, b;
    for (int k = 0; k < NE; k++) a[k] = W'(k + 1);
    rand_vec(b);
    do_load(a, b, 1'b0, 0, 0);
    n_checks++;
    if (bus1.o_A[143:128] !== 16'h0001 || bus1.o_A[15:0] !== 16'h0009) begin
      n_fail++; $display("FAIL packing: msb=%h lsb=%h required 0001 0009",
                         bus1.o_A[143:128], bus1.o_A[15:0]);
    end
    do_run(a, 3);
    do_drain(a, 0);
  endtask

  task automatic test_back_to_back();
    vec9_t a, b, c;
    for (int t = 0; t < 4; t++) begin
      rand_vec(a); rand_vec(b); rand_vec(c);
      do_load(a, b, 1'($urandom_range(0, 1)), 1, 0);
      do_run(c, $urandom_range(0, 10));
      do_drain(c, 1);
    end
  endtask

  task automatic test_spurious_done();
    vec9_t a, b, c;
    rand_vec(a); rand_vec(b); rand_vec(c);
    do_load(a, b, 1'b1, 1, 1);
    do_run(c, 2);
    do_drain(c, 1);
  endtask

  task automatic test_reset_mid_run();
    vec9_t a, b, c;
    rand_vec(a); rand_vec(b); rand_vec(c);
    do_load(a, b, 1'b1, 0, 0);
    bus1.i_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus1.o_en, bus1.o_out_valid, busy1, bus1.o_mode} !== 4'b0000 ||
        bus1.o_A !== '0 || bus1.o_B !== '0 || rc1 !== '0) begin
      n_fail++; $display("FAIL reset_mid_run: en/valid/busy/mode=%b rc=%0d required 0000 0",
                         {bus1.o_en, bus1.o_out_valid, busy1, bus1.o_mode}, rc1);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus1.o_in_ready !== 1'b1 || bus1.o_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_recover: ready=%b en=%b required 1 0", bus1.o_in_ready, bus1.o_en);
    end
    do_load(a, b, 1'b0, 1, 0);
    do_run(c, 4);
    do_drain(c, 1);
  endtask

  task automatic test_saturation();
    vec9_t a, b, c;
    rand_vec(a); rand_vec(b); rand_vec(c);
    do_load(a, b, 1'b0, 0, 0);
    do_run(c, 20);
    do_drain(c, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus1.i_mode = 1'b0; bus1.i_in_valid = 1'b0; bus1.i_in_data = '0;
    bus1.i_out_ready = 1'b0; bus1.i_C = '0; bus1.i_done = 1'b0;
    @(negedge clk);
    test_reset();
    test_all_ones();
    test_packing();
    test_back_to_back();
    test_spurious_done();
    test_reset_mid_run();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mat_mul_host_seq.md
Name: mat_mul_host_seq

Overview:
- Host-side initiator for the systolic `control` unit.
- Accepts a serial stream of W-bit elements: A row-major, then B row-major.
- Assembles the flat o_A/o_B buses, raises o_en, waits for i_done, captures i_C, and streams C back out element by element.
- Replaces hand-driven matrix buses and the enable sequence with a valid/ready stream interface.

Parameters:
W, 16, element width in bits (fp16 payload, e.g. 16'h3c00 = 1.0)
N, 3, matrix dimension (N x N)
CW, 16, width of run-cycle counter

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous active-high reset
i_mode  in  1  mode, latched on first A element accept
i_in_valid  in  1  input element valid
o_in_ready  out  1  input element ready
i_in_data  in  W  input element
o_out_valid  out  1  result element valid
i_out_ready  in  1  result element ready
o_out_data  out  W  result element
o_out_last  out  1  high with final C element
o_en  out  1  enable to control unit
o_mode  out  1  latched mode to control unit
o_A  out  W*N*N  flat A matrix
o_B  out  W*N*N  flat B matrix
i_C  in  W*N*N  flat C matrix from control unit
i_done  in  1  completion from control unit
o_busy  out  1  high in RUN or DRAIN
o_run_cycles  out  CW  o_en-high cycles of last run, saturating

Behaviour:
- Reset values: o_A, o_B, o_out_data, o_run_cycles, o_mode = 0; o_en, o_out_valid, o_out_last, o_busy = 0. Reset state is LOAD_A.
- Reset is synchronous and active-high and overrides everything, including mid-run. o_en drops on the reset edge.
- Element packing: element (r,c), k = r*N+c, occupies bits [W*(N*N-1-k) +: W]. The first streamed element lands at the MSB. The same packing applies to o_A, o_B and i_C.
- Element index counter idx runs 0..N*N-1 and is shared by all states.
- LOAD_A:
  - o_in_ready = 1.
  - Each handshake (valid & ready) writes i_in_data into A slot idx, then idx++.
  - The accept at idx=0 also latches i_mode.
  - Accept at idx=N*N-1 -> idx=0, go to LOAD_B.
- LOAD_B:
  - Same as LOAD_A, but writes B.
  - Accept at idx=N*N-1 -> go to RUN; o_en=1 from the next cycle.
  - o_run_cycles clears to 0 on that edge.
- RUN:
  - o_in_ready = 0; o_A, o_B, o_mode held stable; o_en = 1.
  - o_run_cycles increments every cycle and saturates at 2^CW-1.
  - When i_done=1 is sampled: capture i_C into the C register, o_en=0 next cycle, go to DRAIN, o_out_valid=1 next cycle.
  - Latency: o_en is low exactly 1 cycle after the i_done edge.
- DRAIN:
  - o_out_data = C slot idx; o_out_valid = 1.
  - o_out_last = (idx == N*N-1).
  - On handshake, idx++. Data is held while i_out_ready=0.
  - Handshake with last -> idx=0, o_out_valid=0, go to LOAD_A.
  - A/B registers keep their old values until overwritten.
- i_done sampled outside RUN is ignored. No capture occurs, and no C is produced without a run.
- i_in_valid while o_in_ready=0 is not consumed; the upstream holds the data.
- o_busy = (state==RUN) | (state==DRAIN).
- Back-to-back operation: a new A load may start the cycle after the last-C handshake. Throughput is 1 element/cycle in LOAD and DRAIN.

Test Plan:
- All-ones: stream eighteen 16'h3c00 with mode=1, model i_done 6 cycles after o_en rises with i_C = nine 16'h4200 (3.0). Required: o_A = o_B = nine 16'h3c00; o_en high exactly 7 cycles; o_run_cycles=7; 9 outputs of 16'h4200; o_out_last on the 9th only.
- Packing: A elements 16'h0001..16'h0009. Required: o_A[143:128]=16'h0001, o_A[15:0]=16'h0009. Loop i_C = o_A. Required: output order 1..9.
- Backpressure: toggle i_in_valid and i_out_ready randomly. Required: no element lost or duplicated; o_out_data stable while o_out_valid & !i_out_ready.
- Spurious done: pulse i_done during LOAD_B. Required: no state change, no output valid. A later real run is unaffected.
- Reset mid-RUN: assert i_rst 3 cycles into RUN. Required: o_en=0 on the next edge, all outputs reset, state LOAD_A, o_in_ready=1 the cycle after reset deasserts.
- Saturation: CW=4, i_done after 20 cycles. Required: o_run_cycles=15.
